ram_dist_mp: RTL and testbench



---
 rtl/ram_dist_mp_pkg.sv | 24 ++
 rtl/ram_dist_mp_bank.sv | 63 ++++++
 rtl/ram_dist_mp.sv | 150 +++++++++++++++
 tb/tb_ram_dist_mp.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ram_dist_mp_pkg.sv
// ram_pkg: shared definitions for the multi-port distributed RAM.
//   - ST_INIT / ST_READY : init-sweep FSM state encoding
//   - nb_of()            : number of write-enable lanes for a given word/lane width
//   - lane_of()          : which write-enable lane a given data bit belongs to
//   - byte_mask_bit()    : one bit of the per-bit write mask expanded from the lane enables
package ram_pkg;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    function automatic int nb_of(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    function automatic int lane_of(input int bit_idx, input int byte_width);
        return bit_idx / byte_width;
    endfunction

    // Expansion is done one data bit at a time so the helper stays width-agnostic.
    function automatic logic byte_mask_bit(input logic lane_en);
        return lane_en;
    endfunction

endpackage

// File: rtl/ram_dist_mp_bank.sv
// ram_dist_bank: one distributed RAM bank, single write port with byte-lane
// mask, single asynchronous read port behind a load-enabled address register.
// Ports:
//   clk, reset                 clock, synchronous active-high reset (address reg only)
//   we, wr_addr, wr_data, wr_be write strobe, address, data, per-lane enables
//   rd_en, rd_addr             address-register load enable and next address
//   rd_addr_q                  registered read address (for address-0 masking upstream)
//   rd_data                    combinational read of storage at rd_addr_q
module ram_dist_bank
    import ram_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 5,
    parameter int BYTEWIDTH = 8,
    localparam int NB = nb_of(DATAWIDTH, BYTEWIDTH),
    localparam int DEPTH = 2 ** ADDRWIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] wr_addr,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic [NB-1:0]        wr_be,
    input  logic                 rd_en,
    input  logic [ADDRWIDTH-1:0] rd_addr,
    output logic [ADDRWIDTH-1:0] rd_addr_q,
    output logic [DATAWIDTH-1:0] rd_data
);

    logic [DATAWIDTH-1:0] mem_r [DEPTH];
    logic [DATAWIDTH-1:0] mask_s;
    logic [ADDRWIDTH-1:0] rd_addr_r;

    // Expand lane enables into a per-bit write mask.
    always_comb begin
        mask_s = {DATAWIDTH{1'b0}};
        for (int i = 0; i < DATAWIDTH; i++) begin
            mask_s[i] = byte_mask_bit(wr_be[lane_of(i, BYTEWIDTH)]);
        end
    end

    // Storage write; masked-off lanes keep their old contents. No reset on the array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= (mem_r[wr_addr] & ~mask_s) | (wr_data & mask_s);
        end
    end

    // Read address register; holds when rd_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_r <= {ADDRWIDTH{1'b0}};
        end else if (rd_en) begin
            rd_addr_r <= rd_addr;
        end
    end

    // A write and an address load at the same edge both land before this read,
    // so the read is naturally write-first.
    assign rd_addr_q = rd_addr_r;
    assign rd_data   = mem_r[rd_addr_r];

endmodule

// File: rtl/ram_dist_mp.sv
// ram_dist_mp: distributed RAM with one byte-enabled write port and RDPORTS
// independent read ports. Storage is replicated per read port. After reset a
// hardware sweep writes INIT_VALUE to every entry; user writes are dropped and
// read data is forced to 0 until the sweep completes.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   wr_data/wr_addr/we/wr_be  write port with per-lane enables
//   rd_addr, rd_en   packed per-port read addresses and address-load enables
//   rd_data          packed per-port read data (latency 1, or 2 with RD_REG)
//   init_busy        high while the init sweep runs
module ram_dist_mp
    import ram_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 5,
    parameter int RDPORTS = 2,
    parameter int BYTEWIDTH = 8,
    parameter bit RD_REG = 1'b0,
    parameter bit ZERO_ADDR0 = 1'b0,
    parameter logic [DATAWIDTH-1:0] INIT_VALUE = {DATAWIDTH{1'b0}},
    localparam int NB = nb_of(DATAWIDTH, BYTEWIDTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATAWIDTH-1:0]           wr_data,
    input  logic [ADDRWIDTH-1:0]           wr_addr,
    input  logic                           we,
    input  logic [NB-1:0]                  wr_be,
    input  logic [RDPORTS*ADDRWIDTH-1:0]   rd_addr,
    input  logic [RDPORTS-1:0]             rd_en,
    output logic [RDPORTS*DATAWIDTH-1:0]   rd_data,
    output logic                           init_busy
);

    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = {ADDRWIDTH{1'b1}};
    localparam logic [ADDRWIDTH-1:0] ZERO_A    = {ADDRWIDTH{1'b0}};

    logic [0:0]           state_r;
    logic [ADDRWIDTH-1:0] cnt_r;
    logic                 init_busy_r;

    logic                 bank_we_s;
    logic [ADDRWIDTH-1:0] bank_addr_s;
    logic [DATAWIDTH-1:0] bank_data_s;
    logic [NB-1:0]        bank_be_s;
    logic                 in_init_s;

    // Init FSM: sweep counter runs once through every address, then READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_INIT;
            cnt_r       <= {ADDRWIDTH{1'b0}};
            init_busy_r <= 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_r <= cnt_r + ADDRWIDTH'(1'b1);
                    if (cnt_r == LAST_ADDR) begin
                        state_r     <= ST_READY;
                        init_busy_r <= 1'b0;
                    end
                end
                ST_READY: begin
                    state_r <= ST_READY;
                end
                default: begin
                    state_r     <= ST_INIT;
                    cnt_r       <= {ADDRWIDTH{1'b0}};
                    init_busy_r <= 1'b1;
                end
            endcase
        end
    end

    assign init_busy = init_busy_r;
    assign in_init_s = (state_r != ST_READY);

    // Write mux: the sweep owns the write port during INIT; user writes are dropped.
    always_comb begin
        bank_we_s   = 1'b0;
        bank_addr_s = wr_addr;
        bank_data_s = wr_data;
        bank_be_s   = wr_be;
        if (reset) begin
            bank_we_s = 1'b0;
        end else if (in_init_s) begin
            bank_we_s   = 1'b1;
            bank_addr_s = cnt_r;
            bank_data_s = INIT_VALUE;
            bank_be_s   = {NB{1'b1}};
        end else if (ZERO_ADDR0 && (wr_addr == ZERO_A)) begin
            bank_we_s = 1'b0;
        end else begin
            bank_we_s = we;
        end
    end

    for (genvar p = 0; p < RDPORTS; p++) begin : g_port
        logic [ADDRWIDTH-1:0] raddr_q_s;
        logic [DATAWIDTH-1:0] raw_s;
        logic [DATAWIDTH-1:0] data_s;

        ram_dist_bank #(
            .DATAWIDTH (DATAWIDTH),
            .ADDRWIDTH (ADDRWIDTH),
            .BYTEWIDTH (BYTEWIDTH)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .we        (bank_we_s),
            .wr_addr   (bank_addr_s),
            .wr_data   (bank_data_s),
            .wr_be     (bank_be_s),
            .rd_en     (rd_en[p]),
            .rd_addr   (rd_addr[p*ADDRWIDTH +: ADDRWIDTH]),
            .rd_addr_q (raddr_q_s),
            .rd_data   (raw_s)
        );

        // Read masking: zero during INIT and, optionally, for address 0.
        always_comb begin
            data_s = raw_s;
            if (in_init_s) begin
                data_s = {DATAWIDTH{1'b0}};
            end else if (ZERO_ADDR0 && (raddr_q_s == ZERO_A)) begin
                data_s = {DATAWIDTH{1'b0}};
            end else begin
                data_s = raw_s;
            end
        end

        if (RD_REG) begin : g_oreg
            logic [DATAWIDTH-1:0] out_r;

            // Optional output register; loads every cycle regardless of rd_en.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_r <= {DATAWIDTH{1'b0}};
                end else begin
                    out_r <= data_s;
                end
            end

            assign rd_data[p*DATAWIDTH +: DATAWIDTH] = out_r;
        end else begin : g_noreg
            assign rd_data[p*DATAWIDTH +: DATAWIDTH] = data_s;
        end
    end

endmodule

// File: tb/tb_ram_dist_mp.sv
// Self-checking bench for ram_dist_mp. Three instances share one stimulus:
// default parameters, ZERO_ADDR0=1, and RD_REG=1.
module tb_ram_dist_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wr_data;
    logic [4:0]  wr_addr;
    logic        we;
    logic [3:0]  wr_be;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_en;

    logic [63:0] rd_data_d, rd_data_z, rd_data_r;
    logic        busy_d, busy_z, busy_r;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    ram_dist_mp u_dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr), .we(we),
        .wr_be(wr_be), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data_d),
        .init_busy(busy_d)
    );

    ram_dist_mp #(.ZERO_ADDR0(1'b1)) u_zero (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr), .we(we),
        .wr_be(wr_be), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data_z),
        .init_busy(busy_z)
    );

    ram_dist_mp #(.RD_REG(1'b1)) u_oreg (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr), .we(we),
        .wr_be(wr_be), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data_r),
        .init_busy(busy_r)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] en);
        rd_addr = {a1, a0};
        rd_en   = en;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        we = 1'b0;
    endtask

    // Count edges until init_busy drops; rd_data must stay 0 throughout.
    task automatic sweep_len(input string tag, input logic [4:0] drop_addr);
        int n;
        n = 0;
        while (busy_d === 1'b1 && n < 40) begin
            check_eq({tag, "_rd0_init"}, rd_data_d[31:0] | rd_data_d[63:32], 32'h0);
            we = (n == 5) ? 1'b1 : 1'b0;
            wr_addr = drop_addr; wr_data = 32'hBEEF_0000; wr_be = 4'hF;
            tick();
            n++;
        end
        we = 1'b0;
        check_eq({tag, "_edges"}, 32'(n), 32'd32);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; wr_addr = 5'd0; wr_data = 32'h0; wr_be = 4'h0;
        set_rd(5'd4, 5'd9, 2'b11);
        tick();
        reset = 1'b0;
        check_eq("reset_busy", 32'(busy_d), 32'd1);
        check_eq("reset_rd", rd_data_d[31:0], 32'h0);
        sweep_len("init1", 5'd30);

        // Every address reads INIT_VALUE on both ports.
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a), 2'b11);
            tick();
            check_eq("sweep_p0", rd_data_d[31:0], 32'h0);
            check_eq("sweep_p1", rd_data_d[63:32], 32'h0);
        end

        // Byte-lane merge.
        wr(5'd5, 32'hDEAD_BEEF, 4'b1111);
        wr(5'd5, 32'h0000_AA00, 4'b0010);
        set_rd(5'd5, 5'd6, 2'b11);
        tick();
        check_eq("be_merge", rd_data_d[31:0], 32'hDEAD_AAEF);

        // Write-first at the address-load edge, both ports on the same address.
        set_rd(5'd3, 5'd3, 2'b11);
        wr(5'd3, 32'h1234_5678, 4'hF);
        set_rd(5'd9, 5'd9, 2'b00);
        check_eq("wf_p0", rd_data_d[31:0], 32'h1234_5678);
        check_eq("wf_p1", rd_data_d[63:32], 32'h1234_5678);
        wr(5'd3, 32'h0000_0001, 4'hF);
        check_eq("held_p0", rd_data_d[31:0], 32'h0000_0001);
        check_eq("held_p1", rd_data_d[63:32], 32'h0000_0001);
        wr(5'd3, 32'hFFFF_FFFF, 4'h0);
        check_eq("be_zero_noop", rd_data_d[31:0], 32'h0000_0001);

        // Address 0 hardwired to zero on the ZERO_ADDR0 instance only.
        wr(5'd0, 32'hFFFF_FFFF, 4'hF);
        wr(5'd1, 32'hFFFF_FFFF, 4'hF);
        set_rd(5'd0, 5'd1, 2'b11);
        tick();
        check_eq("z_addr0", rd_data_z[31:0], 32'h0);
        check_eq("z_addr1", rd_data_z[63:32], 32'hFFFF_FFFF);
        check_eq("d_addr0", rd_data_d[31:0], 32'hFFFF_FFFF);

        // Output register: latency 2, first edge still shows the previous (zero) entry.
        wr(5'd7, 32'h0000_0055, 4'hF);
        set_rd(5'd10, 5'd10, 2'b11);
        tick();
        tick();
        check_eq("oreg_pre", rd_data_r[31:0], 32'h0);
        set_rd(5'd7, 5'd10, 2'b11);
        tick();
        check_eq("oreg_lat1", rd_data_r[31:0], 32'h0);
        check_eq("noreg_lat1", rd_data_d[31:0], 32'h0000_0055);
        tick();
        check_eq("oreg_lat2", rd_data_r[31:0], 32'h0000_0055);

        // Reset mid-sweep restarts it; writes during INIT are dropped.
        wr(5'd12, 32'h0000_CAFE, 4'hF);
        set_rd(5'd7, 5'd12, 2'b11);
        tick();
        check_eq("cafe", rd_data_d[63:32], 32'h0000_CAFE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            we = (i == 3) ? 1'b1 : 1'b0;
            wr_addr = 5'd20; wr_data = 32'h1111_2222; wr_be = 4'hF;
            tick();
        end
        we = 1'b0;
        check_eq("mid_busy", 32'(busy_d), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sweep_len("init2", 5'd21);
        set_rd(5'd12, 5'd20, 2'b11);
        tick();
        check_eq("cafe_cleared", rd_data_d[31:0], 32'h0);
        check_eq("drop_a20", rd_data_d[63:32], 32'h0);
        set_rd(5'd21, 5'd7, 2'b11);
        tick();
        check_eq("drop_a21", rd_data_d[31:0], 32'h0);
        check_eq("a7_cleared", rd_data_d[63:32], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
